// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock through a registered carry,
// with a start/busy/done handshake, carry-out and signed overflow.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $fatal(1, "serial_chunk_adder: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_accept;
    logic             w_last;
    logic [CHUNK:0]   w_sum;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;

    // Operands shift right so the active chunk is always in the low bits.
    generate
        if (NCHUNK > 1) begin : g_shift
            assign w_a_shift = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
            assign w_b_shift = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
        end else begin : g_no_shift
            assign w_a_shift = '0;
            assign w_b_shift = '0;
        end
    endgenerate

    assign w_accept  = start && (r_state != RUN);
    assign w_last    = (r_k == K_LAST);
    assign w_sum     = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    assign w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = start ? RUN : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= op ? ~B : B;
            r_carry <= Cin;
            r_s     <= '0;
            r_k     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == RUN) begin
            r_s[r_k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            r_carry                 <= w_sum[CHUNK];
            r_a                     <= w_a_shift;
            r_b                     <= w_b_shift;
            r_k                     <= r_k + 1'b1;
            if (w_last) begin
                r_cout <= w_sum[CHUNK];
                r_ovf  <= w_msb_cin ^ w_sum[CHUNK];
            end
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
    assign ovf  = r_ovf;

endmodule
